// File: rtl/preempt_scheduler.sv
// -----------------------------------------------------------------------------
// preempt_scheduler
//
// Preemptive round-robin quantum scheduler. Holds one quantum per process slot,
// counts down the running slot's quantum, and raises `interrupt` on expiry or
// when the running process finishes. The interrupt is held until the BIOS
// acknowledges it with FLAG_IMoffset, at which point the next active slot
// (round-robin) is loaded and counting resumes on the following cycle.
//
// Ports:
//   clock          processor clock
//   reset          synchronous, active-high
//   quantum        quantum value written by FLAG_spawn (0 -> DEFAULT_QUANTUM)
//   slot_sel       target slot for FLAG_spawn / FLAG_timer
//   FLAG_spawn     write quantum table entry and mark slot active
//   FLAG_timer     arm: start running slot_sel
//   halt, FLAG_input, FLAG_output   freeze counting while any is high
//   finish         running process ended
//   FLAG_IMoffset  context-switch acknowledge
//   interrupt      switch request, held until acknowledged
//   current_slot   running slot
//   next_slot      round-robin successor (combinational)
//   remaining      cycles left in the current quantum
//   active_mask    one bit per live slot
//   idle           no slot is active (combinational)
//
// Optional build macro PREEMPT_STATS_EN adds:
//   switch_count   saturating count of accepted acknowledges
//   expired_mask   per-slot "quantum expired" flags, cleared by spawn
// -----------------------------------------------------------------------------
module preempt_scheduler #(
  parameter int WORD_SIZE       = 32,
  parameter int SLOTS           = 4,
  parameter int SLOT_WIDTH      = 2,
  parameter int DEFAULT_QUANTUM = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_SIZE-1:0]  quantum,
  input  logic [SLOT_WIDTH-1:0] slot_sel,
  input  logic                  FLAG_spawn,
  input  logic                  FLAG_timer,
  input  logic                  halt,
  input  logic                  FLAG_input,
  input  logic                  FLAG_output,
  input  logic                  finish,
  input  logic                  FLAG_IMoffset,
  output logic                  interrupt,
  output logic [SLOT_WIDTH-1:0] current_slot,
  output logic [SLOT_WIDTH-1:0] next_slot,
  output logic [WORD_SIZE-1:0]  remaining,
  output logic [SLOTS-1:0]      active_mask,
  output logic                  idle
`ifdef PREEMPT_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]  switch_count,
  output logic [SLOTS-1:0]      expired_mask
`endif
);

  localparam logic [WORD_SIZE-1:0] DEFAULT_Q = WORD_SIZE'(DEFAULT_QUANTUM);
  localparam logic [WORD_SIZE-1:0] ONE       = WORD_SIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND
  } state_t;

  state_t                  state_q, state_d;
  logic                    interrupt_d;
  logic [SLOT_WIDTH-1:0]   slot_d;
  logic [WORD_SIZE-1:0]    remaining_d;
  logic [SLOTS-1:0]        mask_d;
  logic [WORD_SIZE-1:0]    spawn_value;
  logic                    frozen;
  logic [WORD_SIZE-1:0]    quantum_table [SLOTS];

  assign spawn_value = (quantum == '0) ? DEFAULT_Q : quantum;
  assign frozen      = halt | FLAG_input | FLAG_output;
  assign idle        = ~|active_mask;

  // Quantum table. Entries must read DEFAULT_QUANTUM after reset so that arming
  // a never-spawned slot still yields a defined quantum.
  // NOTE: this small table is deliberately reset; larger RAM-style storage
  // normally is not, since a reset forces it into flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) quantum_table[i] <= DEFAULT_Q;
    end else if (FLAG_spawn) begin
      quantum_table[slot_sel] <= spawn_value;
    end
  end

  // Round-robin successor: scan current+1 .. current+SLOTS (wrapping), so the
  // current slot is examined last. With no active slot, stay on current.
  logic [SLOT_WIDTH-1:0] cand;
  logic                  found;

  always_comb begin
    next_slot = current_slot;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= SLOTS; i++) begin
      cand = current_slot + SLOT_WIDTH'(i);
      if (!found && active_mask[cand]) begin
        next_slot = cand;
        found     = 1'b1;
      end
    end
  end

  // Next-state logic. Event priority: timer > finish > acknowledge > decrement.
  // Spawn is applied last to the mask so its "set" beats a finish "clear".
  // NOTE: every output of this block gets a default first, so no path through
  // the if/else chain can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt;
    slot_d      = current_slot;
    remaining_d = remaining;
    mask_d      = active_mask;

    if (FLAG_timer) begin
      slot_d           = slot_sel;
      // A same-cycle spawn to this slot supplies the fresh quantum.
      remaining_d      = FLAG_spawn ? spawn_value : quantum_table[slot_sel];
      interrupt_d      = 1'b0;
      state_d          = S_RUN;
      mask_d[slot_sel] = 1'b1;
    end else if (finish && (state_q != S_IDLE)) begin
      mask_d[current_slot] = 1'b0;
      remaining_d          = '0;
      interrupt_d          = 1'b1;
      state_d              = S_PEND;
    end else if (FLAG_IMoffset && (state_q == S_PEND)) begin
      interrupt_d = 1'b0;
      slot_d      = next_slot;
      if (|active_mask) begin
        remaining_d = quantum_table[next_slot];
        state_d     = S_RUN;
      end else begin
        remaining_d = '0;
        state_d     = S_IDLE;
      end
    end else if ((state_q == S_RUN) && !frozen) begin
      if (remaining <= ONE) begin
        remaining_d = '0;
        interrupt_d = 1'b1;
        state_d     = S_PEND;
      end else begin
        remaining_d = remaining - ONE;
      end
    end

    if (FLAG_spawn) mask_d[slot_sel] = 1'b1;
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      interrupt    <= 1'b0;
      current_slot <= '0;
      remaining    <= '0;
      active_mask  <= '0;
    end else begin
      state_q      <= state_d;
      interrupt    <= interrupt_d;
      current_slot <= slot_d;
      remaining    <= remaining_d;
      active_mask  <= mask_d;
    end
  end

`ifdef PREEMPT_STATS_EN
  // RUN -> PEND without finish can only be an expiry (timer keeps RUN).
  logic             expire_evt;
  logic             switch_evt;
  logic [SLOTS-1:0] expired_d;

  assign expire_evt = (state_q == S_RUN) && (state_d == S_PEND) && !finish;
  assign switch_evt = (state_q == S_PEND) && FLAG_IMoffset && !FLAG_timer && !finish;

  always_comb begin
    expired_d = expired_mask;
    if (expire_evt) expired_d[current_slot] = 1'b1;
    if (FLAG_spawn) expired_d[slot_sel]     = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      switch_count <= '0;
      expired_mask <= '0;
    end else begin
      if (switch_evt && (switch_count != '1)) switch_count <= switch_count + ONE;
      expired_mask <= expired_d;
    end
  end
`endif

endmodule

// File: tb/tb_preempt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_preempt_scheduler
//
// Self-checking bench for preempt_scheduler. Each scenario is a list of
// per-cycle rows (command + expected registered state). Driving a row pushes
// its expectation onto a scoreboard; after the clock edge the expectation is
// popped and compared with the DUT outputs sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_preempt_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] quantum = '0;
  logic [1:0]  slot_sel = '0;
  logic        FLAG_spawn = 1'b0;
  logic        FLAG_timer = 1'b0;
  logic        halt = 1'b0;
  logic        FLAG_input = 1'b0;
  logic        FLAG_output = 1'b0;
  logic        finish = 1'b0;
  logic        FLAG_IMoffset = 1'b0;
  logic        interrupt;
  logic [1:0]  current_slot;
  logic [1:0]  next_slot;
  logic [31:0] remaining;
  logic [3:0]  active_mask;
  logic        idle;
`ifdef PREEMPT_STATS_EN
  logic [31:0] switch_count;
  logic [3:0]  expired_mask;
`endif

  preempt_scheduler #(
    .WORD_SIZE(32), .SLOTS(4), .SLOT_WIDTH(2), .DEFAULT_QUANTUM(64)
  ) dut (
    .clock(clock), .reset(reset), .quantum(quantum), .slot_sel(slot_sel),
    .FLAG_spawn(FLAG_spawn), .FLAG_timer(FLAG_timer), .halt(halt),
    .FLAG_input(FLAG_input), .FLAG_output(FLAG_output), .finish(finish),
    .FLAG_IMoffset(FLAG_IMoffset), .interrupt(interrupt),
    .current_slot(current_slot), .next_slot(next_slot), .remaining(remaining),
    .active_mask(active_mask), .idle(idle)
`ifdef PREEMPT_STATS_EN
    , .switch_count(switch_count), .expired_mask(expired_mask)
`endif
  );

  always #5 clock = ~clock;

  typedef enum {
    C_NONE, C_SPAWN, C_TIMER, C_SPAWN_TIMER, C_FINISH, C_ACK,
    C_HALT, C_INPUT, C_OUTPUT, C_RESET
  } cmd_t;

  typedef struct packed {
    logic        intr;
    logic [31:0] rem;
    logic [1:0]  cur;
    logic [1:0]  nxt;
    logic [3:0]  mask;
  } snap_t;

  typedef struct {
    string      tag;
    cmd_t       cmd;
    logic [1:0] sel;
    logic [31:0] q;
    snap_t      exp;
  } row_t;

  typedef struct {
    string tag;
    snap_t val;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  function automatic row_t r(string tag, cmd_t cmd, logic [1:0] sel, logic [31:0] q,
                             logic ei, logic [31:0] er, logic [1:0] ec,
                             logic [1:0] en, logic [3:0] em);
    row_t x;
    x.tag = tag;
    x.cmd = cmd;
    x.sel = sel;
    x.q   = q;
    x.exp = '{intr: ei, rem: er, cur: ec, nxt: en, mask: em};
    return x;
  endfunction

  function automatic snap_t snap();
    return '{intr: interrupt, rem: remaining, cur: current_slot,
             nxt: next_slot, mask: active_mask};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("int=%b rem=%0d cur=%0d next=%0d mask=%b",
                     s.intr, s.rem, s.cur, s.nxt, s.mask);
  endfunction

  task automatic release_inputs();
    reset = 1'b0; FLAG_spawn = 1'b0; FLAG_timer = 1'b0; halt = 1'b0;
    FLAG_input = 1'b0; FLAG_output = 1'b0; finish = 1'b0; FLAG_IMoffset = 1'b0;
  endtask

  task automatic apply(input row_t x);
    release_inputs();
    slot_sel = x.sel;
    quantum  = x.q;
    case (x.cmd)
      C_SPAWN:       FLAG_spawn = 1'b1;
      C_TIMER:       FLAG_timer = 1'b1;
      C_SPAWN_TIMER: begin FLAG_spawn = 1'b1; FLAG_timer = 1'b1; end
      C_FINISH:      finish = 1'b1;
      C_ACK:         FLAG_IMoffset = 1'b1;
      C_HALT:        halt = 1'b1;
      C_INPUT:       FLAG_input = 1'b1;
      C_OUTPUT:      FLAG_output = 1'b1;
      C_RESET:       reset = 1'b1;
      default:       ;
    endcase
    sb.push_back('{tag: x.tag, val: x.exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("reset_init", C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("rst_spawn1", C_SPAWN, 2'd1, 32'd9, 1'b0, 32'd0, 2'd0, 2'd1, 4'b0010));
    rows.push_back(r("rst_arm1",   C_TIMER, 2'd1, 32'd0, 1'b0, 32'd9, 2'd1, 2'd1, 4'b0010));
    rows.push_back(r("rst_count",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd8, 2'd1, 2'd1, 4'b0010));
    rows.push_back(r("rst_midq",   C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    tests++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: got %b, want 1", idle);
    end
    release_inputs();
  endtask

  task automatic test_basic_count();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("bc_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("bc_spawn0", C_SPAWN, 2'd0, 32'd5, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("bc_arm0",   C_TIMER, 2'd0, 32'd0, 1'b0, 32'd5, 2'd0, 2'd0, 4'b0001));
    for (int k = 4; k >= 1; k--)
      rows.push_back(r("bc_count", C_NONE, 2'd0, 32'd0, 1'b0, 32'(k), 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("bc_expire", C_NONE, 2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("bc_pend",   C_NONE, 2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("bc_ack",    C_ACK,  2'd0, 32'd0, 1'b0, 32'd5, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("bc_recount",C_NONE, 2'd0, 32'd0, 1'b0, 32'd4, 2'd0, 2'd0, 4'b0001));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    release_inputs();
  endtask

  task automatic test_freeze();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("fz_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fz_spawn0", C_SPAWN, 2'd0, 32'd5, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_arm0",   C_TIMER, 2'd0, 32'd0, 1'b0, 32'd5, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_e1",     C_NONE,  2'd0, 32'd0, 1'b0, 32'd4, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_e2",     C_NONE,  2'd0, 32'd0, 1'b0, 32'd3, 2'd0, 2'd0, 4'b0001));
    for (int k = 0; k < 3; k++)
      rows.push_back(r("fz_input", C_INPUT, 2'd0, 32'd0, 1'b0, 32'd3, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_e6",     C_NONE,  2'd0, 32'd0, 1'b0, 32'd2, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_e7",     C_NONE,  2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_halt_at1", C_HALT, 2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fz_expire", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd0, 4'b0001));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    release_inputs();
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("rr_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("rr_spawn0", C_SPAWN, 2'd0, 32'd2, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("rr_spawn1", C_SPAWN, 2'd1, 32'd3, 1'b0, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("rr_spawn3", C_SPAWN, 2'd3, 32'd2, 1'b0, 32'd0, 2'd0, 2'd1, 4'b1011));
    rows.push_back(r("rr_arm1",   C_TIMER, 2'd1, 32'd0, 1'b0, 32'd3, 2'd1, 2'd3, 4'b1011));
    rows.push_back(r("rr_s1_c2",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd2, 2'd1, 2'd3, 4'b1011));
    rows.push_back(r("rr_s1_c1",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd1, 2'd1, 2'd3, 4'b1011));
    rows.push_back(r("rr_s1_exp", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd1, 2'd3, 4'b1011));
    rows.push_back(r("rr_ack_to3",C_ACK,   2'd0, 32'd0, 1'b0, 32'd2, 2'd3, 2'd0, 4'b1011));
    rows.push_back(r("rr_s3_halt",C_HALT,  2'd0, 32'd0, 1'b0, 32'd2, 2'd3, 2'd0, 4'b1011));
    rows.push_back(r("rr_s3_c1",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd1, 2'd3, 2'd0, 4'b1011));
    rows.push_back(r("rr_s3_exp", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd3, 2'd0, 4'b1011));
    rows.push_back(r("rr_ack_to0",C_ACK,   2'd0, 32'd0, 1'b0, 32'd2, 2'd0, 2'd1, 4'b1011));
    rows.push_back(r("rr_s0_out", C_OUTPUT,2'd0, 32'd0, 1'b0, 32'd2, 2'd0, 2'd1, 4'b1011));
    rows.push_back(r("rr_s0_c1",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd1, 4'b1011));
    rows.push_back(r("rr_s0_exp", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd1, 4'b1011));
    rows.push_back(r("rr_ack_to1",C_ACK,   2'd0, 32'd0, 1'b0, 32'd3, 2'd1, 2'd3, 4'b1011));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    release_inputs();
  endtask

  task automatic test_default_quantum();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("dq_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("dq_spawn2", C_SPAWN, 2'd2, 32'd0, 1'b0, 32'd0,  2'd0, 2'd2, 4'b0100));
    rows.push_back(r("dq_arm2",   C_TIMER, 2'd2, 32'd0, 1'b0, 32'd64, 2'd2, 2'd2, 4'b0100));
    for (int k = 63; k >= 1; k--)
      rows.push_back(r("dq_count", C_NONE, 2'd0, 32'd0, 1'b0, 32'(k), 2'd2, 2'd2, 4'b0100));
    rows.push_back(r("dq_expire", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0,  2'd2, 2'd2, 4'b0100));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    release_inputs();
  endtask

  task automatic test_spawn_arm();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("sa_rst",       C_RESET,       2'd0, 32'd0, 1'b0, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("sa_arm_unspawned", C_TIMER,   2'd3, 32'd0, 1'b0, 32'd64, 2'd3, 2'd3, 4'b1000));
    rows.push_back(r("sa_spawn_arm1",C_SPAWN_TIMER, 2'd1, 32'd7, 1'b0, 32'd7,  2'd1, 2'd3, 4'b1010));
    rows.push_back(r("sa_count",     C_NONE,        2'd0, 32'd0, 1'b0, 32'd6,  2'd1, 2'd3, 4'b1010));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    release_inputs();
  endtask

  task automatic test_finish();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("fn_rst",    C_RESET, 2'd0, 32'd0,  1'b0, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fn_spawn0", C_SPAWN, 2'd0, 32'd10, 1'b0, 32'd0,  2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fn_arm0",   C_TIMER, 2'd0, 32'd0,  1'b0, 32'd10, 2'd0, 2'd0, 4'b0001));
    for (int k = 9; k >= 3; k--)
      rows.push_back(r("fn_count", C_NONE, 2'd0, 32'd0, 1'b0, 32'(k), 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("fn_finish", C_FINISH,2'd0, 32'd0,  1'b1, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fn_pend",   C_NONE,  2'd0, 32'd0,  1'b1, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fn_ack_idle", C_ACK, 2'd0, 32'd0,  1'b0, 32'd0,  2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fn_idle_hold", C_NONE, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("fn_spawn2", C_SPAWN, 2'd2, 32'd4,  1'b0, 32'd0,  2'd0, 2'd2, 4'b0100));
    rows.push_back(r("fn_finish_in_idle", C_FINISH, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd2, 4'b0100));
    rows.push_back(r("fn_ack_in_idle",    C_ACK,    2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd2, 4'b0100));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
      if (rows[k].tag == "fn_ack_idle") begin
        tests++;
        if (idle !== 1'b1) begin
          fails++;
          $display("FAIL fn_idle_flag: got %b, want 1", idle);
        end
      end
    end
    release_inputs();
  endtask

  task automatic test_reset_in_pend();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("rp_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("rp_spawn0", C_SPAWN, 2'd0, 32'd2, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("rp_spawn1", C_SPAWN, 2'd1, 32'd2, 1'b0, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("rp_arm0",   C_TIMER, 2'd0, 32'd0, 1'b0, 32'd2, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("rp_count",  C_NONE,  2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("rp_expire", C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("rp_reset",  C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
    end
    tests++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL rp_idle: got %b, want 1", idle);
    end
    release_inputs();
  endtask

`ifdef PREEMPT_STATS_EN
  task automatic test_stats();
    row_t rows[$];
    sb_t e;
    snap_t got;
    rows.push_back(r("st_rst",    C_RESET, 2'd0, 32'd0, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0000));
    rows.push_back(r("st_spawn0", C_SPAWN, 2'd0, 32'd1, 1'b0, 32'd0, 2'd0, 2'd0, 4'b0001));
    rows.push_back(r("st_spawn1", C_SPAWN, 2'd1, 32'd1, 1'b0, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("st_arm0",   C_TIMER, 2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("st_exp0",   C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("st_ack1",   C_ACK,   2'd0, 32'd0, 1'b0, 32'd1, 2'd1, 2'd0, 4'b0011));
    rows.push_back(r("st_exp1",   C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd1, 2'd0, 4'b0011));
    rows.push_back(r("st_ack2",   C_ACK,   2'd0, 32'd0, 1'b0, 32'd1, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("st_exp2",   C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd0, 2'd1, 4'b0011));
    rows.push_back(r("st_ack3",   C_ACK,   2'd0, 32'd0, 1'b0, 32'd1, 2'd1, 2'd0, 4'b0011));
    rows.push_back(r("st_exp3",   C_NONE,  2'd0, 32'd0, 1'b1, 32'd0, 2'd1, 2'd0, 4'b0011));
    rows.push_back(r("st_respawn0", C_SPAWN, 2'd0, 32'd1, 1'b1, 32'd0, 2'd1, 2'd0, 4'b0011));
    foreach (rows[k]) begin
      apply(rows[k]);
      tick();
      e = sb.pop_front();
      got = snap();
      tests++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %s, want %s", e.tag, fmt(got), fmt(e.val));
      end
      if (rows[k].tag == "st_exp3") begin
        tests++;
        if (switch_count !== 32'd3) begin
          fails++;
          $display("FAIL st_switch_count: got %0d, want 3", switch_count);
        end
        tests++;
        if (expired_mask !== 4'b0011) begin
          fails++;
          $display("FAIL st_expired_mask: got %b, want 0011", expired_mask);
        end
      end
    end
    tests++;
    if (expired_mask !== 4'b0010) begin
      fails++;
      $display("FAIL st_expired_clear: got %b, want 0010", expired_mask);
    end
    release_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_freeze();
    test_round_robin();
    test_default_quantum();
    test_spawn_arm();
    test_finish();
    test_reset_in_pend();
`ifdef PREEMPT_STATS_EN
    test_stats();
`endif
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
